bsg_nasti_resp_sched: RTL and testbench
=======================================

# bsg_nasti_resp_sched

Response scheduler that merges the NASTI read-data (R) and write-response (B) channels onto the single tunnel demux response stream toward the chip-to-chip link. R bursts stay atomic: once an R burst starts, no B beat is interleaved until the R beat with last set is accepted. Between packets, arbitration is round-robin. The output is one registered stage, and a sticky error flags bursts longer than the configured maximum.

## Interface
- width_p, 64: payload width of one R beat or B beat (packed id/data/resp fields, opaque to this block)
- max_beats_p, 8: maximum legal R burst length in beats; must be ≥ 1
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low; all state clears on assertion
- r_v_i  in  1  R beat valid
- r_data_i  in  width_p  R beat payload
- r_last_i  in  1  final beat of R burst
- r_yumi_o  out  1  R beat consumed this cycle
- b_v_i  in  1  B beat valid
- b_data_i  in  width_p  B beat payload
- b_yumi_o  out  1  B beat consumed this cycle
- resp_v_o  out  1  output register holds a beat
- resp_data_o  out  width_p+2  {src, last, payload}; src=1 for R, 0 for B; last=1 for B beats always
- resp_yumi_i  in  1  downstream consumes output beat; legal only when resp_v_o=1
- err_o  out  1  sticky: an R burst exceeded max_beats_p

## Operation
- Sources use valid/yumi. A beat is accepted when its yumi_o is high, and the yumi is a function of that cycle's inputs and state.
- Output register load enable: ld = ~resp_v_o | resp_yumi_i. At most one of r_yumi_o and b_yumi_o is high in any cycle, and only when ld=1.
- States:
  - IDLE: no burst in progress.
  - R_LOCK: an R burst has started and its last beat has not yet been accepted.
- IDLE grant rules:
  - Only r_v_i → grant R.
  - Only b_v_i → grant B.
  - Both valid → grant the source indicated by priority bit pri_r_q (1 = R).
- R_LOCK grant rules: grant only R, never B, even if b_v_i is high and r_v_i is low.
- State transitions:
  - IDLE→R_LOCK on R accept with r_last_i=0.
  - R_LOCK→IDLE on R accept with r_last_i=1.
  - A single-beat R burst (last=1 in IDLE) stays in IDLE.
- Priority: pri_r_q updates only on packet completion.
  - Accepted B beat → pri_r_q=1.
  - Accepted R beat with last=1 → pri_r_q=0.
  - It is unchanged mid-burst.
- Beat counter: width $clog2(max_beats_p+1).
  - Clears to 0 on entering IDLE.
  - Increments on each R accept; saturates at max_beats_p.
  - If an R beat with r_last_i=0 is accepted while the counter already equals max_beats_p-1, set err_o.
  - err_o stays set until reset. The lock is still held until a last beat arrives; no data is dropped.
- Output register, on each accept:
  - resp_data_o ← {src, r_last_i or 1, payload}.
  - resp_v_o ← 1.
- If resp_yumi_i is high and no accept occurs, resp_v_o ← 0.

## Timing
- Reset values: resp_v_o=0, resp_data_o=0, err_o=0, state=IDLE, pri_r_q=1, counter=0. r_yumi_o and b_yumi_o are 0 whenever there is no valid input.
- Latency: a beat accepted in cycle t appears on resp_v_o and resp_data_o in cycle t+1.
- Full throughput: with resp_yumi_i held high, one beat per cycle passes with no bubbles, including across back-to-back packets.
- Backpressure: with resp_v_o=1 and resp_yumi_i=0, both yumis stay 0 and the output holds stable.
- Simultaneous events: if resp_yumi_i and a new accept occur in the same cycle, the register reloads and resp_v_o stays 1.
- Reset mid-burst: the async assertion discards the output register and lock immediately. After release, arbitration restarts from IDLE with R priority. Upstream must also be reset.
- No combinational path from resp_data_o back to the inputs. Both yumis depend combinationally on v_i, resp_v_o, resp_yumi_i and state.

## Test plan
- Reset release, both sources idle → resp_v_o=0 and err_o=0 for 10 cycles. Then a single B beat 0x11 → resp_data_o={0,1,0x11} one cycle after b_yumi_o.
- R burst of 4 beats (last on beat 4) with b_v_i asserted throughout, resp_yumi_i=1 → outputs R1..R4 on consecutive cycles, then the B beat. b_yumi_o stays 0 during the burst.
- Both sources continuously presenting single-beat packets (r_last_i=1) → strict alternation R,B,R,B starting with R after reset.
- Output stall: hold resp_yumi_i=0 for 5 cycles mid-burst → resp_data_o stable and r_yumi_o=0. On release, no beat is lost or duplicated; order is preserved.
- max_beats_p=8, R burst of 9 beats → err_o rises on acceptance of beat 8 (last=0) and stays 1. All 9 beats are delivered, and IDLE is entered after beat 9.
- Assert reset_n_i low mid-burst (after beat 2 of 4) → resp_v_o drops asynchronously. After release, a pending B is granted immediately.

Source files
------------

// File: rtl/bsg_nasti_resp_sched_if.sv
// Bundle of the three beat streams handled by the response scheduler:
//   R channel    : r_v_i / r_data_i / r_last_i in, r_yumi_o out
//   B channel    : b_v_i / b_data_i in, b_yumi_o out
//   resp channel : resp_v_o / resp_data_o out, resp_yumi_i in
// The slave modport is the scheduler's view; master is the surrounding logic.
interface bsg_nasti_resp_sched_if #(
   parameter int width_p = 64
);
   logic               r_v_i;
   logic [width_p-1:0] r_data_i;
   logic               r_last_i;
   logic               r_yumi_o;
   logic               b_v_i;
   logic [width_p-1:0] b_data_i;
   logic               b_yumi_o;
   logic               resp_v_o;
   logic [width_p+1:0] resp_data_o;
   logic               resp_yumi_i;

   modport slave (
      input  r_v_i, r_data_i, r_last_i,
      output r_yumi_o,
      input  b_v_i, b_data_i,
      output b_yumi_o,
      output resp_v_o, resp_data_o,
      input  resp_yumi_i
   );

   modport master (
      output r_v_i, r_data_i, r_last_i,
      input  r_yumi_o,
      output b_v_i, b_data_i,
      input  b_yumi_o,
      input  resp_v_o, resp_data_o,
      output resp_yumi_i
   );
endinterface

// File: rtl/bsg_nasti_resp_sched.sv
// Merges NASTI R (read data) and B (write response) beats onto one registered
// response stream. R bursts are atomic; between packets arbitration is
// round-robin. A sticky error flags R bursts longer than max_beats_p.
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   bus        : R / B / resp beat streams (slave modport)
//   err_o      : sticky over-length R burst flag
// resp_data_o = {src (1=R,0=B), last (always 1 for B), payload}.
module bsg_nasti_resp_sched #(
   parameter int width_p     = 64,
   parameter int max_beats_p = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   bsg_nasti_resp_sched_if.slave       bus,
   output logic                        err_o
);

   localparam int CNT_W = $clog2(max_beats_p + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      R_LOCK = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic               pri_r_q, pri_r_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               resp_v_q, resp_v_d;
   logic [width_p+1:0] resp_data_q, resp_data_d;
   logic               ld;
   logic               grant_r, grant_b;

   always_comb begin
      ld          = ~resp_v_q | bus.resp_yumi_i;
      grant_r     = 1'b0;
      grant_b     = 1'b0;
      state_d     = state_q;
      pri_r_d     = pri_r_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      resp_v_d    = resp_v_q;
      resp_data_d = resp_data_q;

      // Grants only when the output register can take a beat; while locked
      // on an R burst, B is held off even if R has nothing to offer.
      if (ld) begin
         if (state_q == R_LOCK) begin
            grant_r = bus.r_v_i;
         end else if (bus.r_v_i && bus.b_v_i) begin
            grant_r = pri_r_q;
            grant_b = ~pri_r_q;
         end else begin
            grant_r = bus.r_v_i;
            grant_b = bus.b_v_i;
         end
      end

      if (grant_r) begin
         resp_v_d    = 1'b1;
         resp_data_d = {1'b1, bus.r_last_i, bus.r_data_i};
         if (bus.r_last_i) begin
            state_d = IDLE;
            pri_r_d = 1'b0;
            cnt_d   = '0;
         end else begin
            state_d = R_LOCK;
            // cnt_q counts beats already taken, so this beat is number
            // cnt_q+1; reaching max_beats_p without last means over-length.
            if (cnt_q == CNT_W'(max_beats_p - 1)) begin
               err_d = 1'b1;
            end
            if (cnt_q != CNT_W'(max_beats_p)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end else if (grant_b) begin
         resp_v_d    = 1'b1;
         resp_data_d = {1'b0, 1'b1, bus.b_data_i};
         pri_r_d     = 1'b1;
      end else if (bus.resp_yumi_i) begin
         resp_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         pri_r_q     <= 1'b1;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         resp_v_q    <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         pri_r_q     <= pri_r_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         resp_v_q    <= resp_v_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign bus.r_yumi_o    = grant_r;
   assign bus.b_yumi_o    = grant_b;
   assign bus.resp_v_o    = resp_v_q;
   assign bus.resp_data_o = resp_data_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_bsg_nasti_resp_sched.sv
module tb_bsg_nasti_resp_sched;

   localparam int W    = 64;
   localparam int MAXB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err;

   always #5 clk = ~clk;

   bsg_nasti_resp_sched_if #(.width_p(W)) bus ();

   bsg_nasti_resp_sched #(.width_p(W), .max_beats_p(MAXB)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus),
      .err_o     (err)
   );

   int nchk = 0;
   int nerr = 0;

   // Transaction-level reference: whether an R packet is open, how many beats
   // it has delivered, whose turn it is, and what the output stage holds.
   bit           m_open;
   bit           m_r_turn;
   int           m_beats;
   bit           m_err;
   bit           m_v;
   logic [W+1:0] m_data;

   // observations from the most recent tick
   logic         obs_r_yumi, obs_b_yumi, obs_v, obs_err;
   logic [W+1:0] obs_data;
   bit           exp_r_yumi, exp_b_yumi;
   logic [W+1:0] got_q[$];

   task automatic model_reset();
      m_open   = 0;
      m_r_turn = 1;
      m_beats  = 0;
      m_err    = 0;
      m_v      = 0;
      m_data   = '0;
   endtask

   task automatic idle_inputs();
      bus.r_v_i       = 0;
      bus.r_last_i    = 0;
      bus.r_data_i    = '0;
      bus.b_v_i       = 0;
      bus.b_data_i    = '0;
      bus.resp_yumi_i = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // Drive one cycle of stimulus, record what the DUT does, advance the model.
   task automatic tick(input logic rv, input logic rl, input logic [W-1:0] rd,
                       input logic bv, input logic [W-1:0] bd, input logic ry);
      bit room;
      @(negedge clk);
      bus.r_v_i       = rv;
      bus.r_last_i    = rl;
      bus.r_data_i    = rd;
      bus.b_v_i       = bv;
      bus.b_data_i    = bd;
      bus.resp_yumi_i = ry & m_v;
      #1;
      obs_r_yumi = bus.r_yumi_o;
      obs_b_yumi = bus.b_yumi_o;
      if (bus.resp_yumi_i && bus.resp_v_o) got_q.push_back(bus.resp_data_o);
      room = !m_v || (ry && m_v);
      exp_r_yumi = room && rv && (m_open || !bv || m_r_turn);
      exp_b_yumi = room && bv && !m_open && !exp_r_yumi;
      @(posedge clk);
      #1;
      if (exp_r_yumi) begin
         m_v    = 1;
         m_data = {1'b1, rl, rd};
         if (rl) begin
            m_open   = 0;
            m_beats  = 0;
            m_r_turn = 0;
         end else begin
            m_open  = 1;
            m_beats = m_beats + 1;
            if (m_beats >= MAXB) m_err = 1;
         end
      end else if (exp_b_yumi) begin
         m_v      = 1;
         m_data   = {1'b0, 1'b1, bd};
         m_r_turn = 1;
      end else if (ry && m_v) begin
         m_v = 0;
      end
      obs_v    = bus.resp_v_o;
      obs_data = bus.resp_data_o;
      obs_err  = err;
   endtask

   task automatic drain();
      repeat (3) tick(0, 0, '0, 0, '0, 1);
   endtask

   task automatic test_reset();
      logic [W+1:0] exp_d;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, '0, 0, '0, 0);
         nchk++;
         if (obs_v !== 1'b0 || obs_err !== 1'b0 || obs_r_yumi !== 1'b0 || obs_b_yumi !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle cyc=%0d v=%b err=%b ry=%b by=%b required all 0", i, obs_v, obs_err, obs_r_yumi, obs_b_yumi);
         end
      end
      tick(0, 0, '0, 1, 64'h11, 0);
      nchk++;
      if (obs_b_yumi !== 1'b1) begin
         nerr++;
         $display("FAIL reset_b_yumi got=%b required=1", obs_b_yumi);
      end
      exp_d = {1'b0, 1'b1, 64'h11};
      nchk++;
      if (obs_v !== 1'b1 || obs_data !== exp_d) begin
         nerr++;
         $display("FAIL reset_b_data v=%b got=%h required=%h", obs_v, obs_data, exp_d);
      end
      drain();
   endtask

   task automatic test_r_burst_blocks_b();
      logic [W+1:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         tick(1, i == 3, 64'hA000 + i, 1, 64'hB0B0, 1);
         nchk++;
         if (obs_r_yumi !== 1'b1 || obs_b_yumi !== 1'b0) begin
            nerr++;
            $display("FAIL burst_grant beat=%0d r_yumi=%b b_yumi=%b required 1/0", i, obs_r_yumi, obs_b_yumi);
         end
         exp_d = {1'b1, i == 3, 64'hA000 + i};
         nchk++;
         if (obs_v !== 1'b1 || obs_data !== exp_d) begin
            nerr++;
            $display("FAIL burst_data beat=%0d got=%h required=%h", i, obs_data, exp_d);
         end
      end
      tick(0, 0, '0, 1, 64'hB0B0, 1);
      exp_d = {1'b0, 1'b1, 64'hB0B0};
      nchk++;
      if (obs_b_yumi !== 1'b1 || obs_data !== exp_d) begin
         nerr++;
         $display("FAIL burst_then_b b_yumi=%b got=%h required=%h", obs_b_yumi, obs_data, exp_d);
      end
      drain();
   endtask

   task automatic test_alternation();
      logic [W+1:0] exp_d;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(1, 1, 64'h100 + i, 1, 64'h200 + i, 1);
         exp_d = (i % 2 == 0) ? {1'b1, 1'b1, 64'h100 + i} : {1'b0, 1'b1, 64'h200 + i};
         nchk++;
         if (obs_data !== exp_d || obs_v !== 1'b1) begin
            nerr++;
            $display("FAIL alternation cyc=%0d got=%h required=%h", i, obs_data, exp_d);
         end
      end
      drain();
   endtask

   task automatic test_stall();
      int           k;
      logic [W+1:0] held;
      logic [W+1:0] exp_d;
      do_reset();
      got_q.delete();
      k = 0;
      for (int c = 0; c < 40; c++) begin
         bit stall;
         stall = (c >= 2 && c < 7);
         if (c == 2) held = obs_data;
         tick(k < 6, k == 5, 64'hA0 + k, 0, '0, !stall);
         if (obs_r_yumi) k++;
         if (stall) begin
            nchk++;
            if (obs_r_yumi !== 1'b0 || obs_data !== held || obs_v !== 1'b1) begin
               nerr++;
               $display("FAIL stall_hold cyc=%0d r_yumi=%b got=%h required=%h", c, obs_r_yumi, obs_data, held);
            end
         end
      end
      nchk++;
      if (got_q.size() != 6) begin
         nerr++;
         $display("FAIL stall_count got=%0d required=6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            exp_d = {1'b1, i == 5, 64'hA0 + i};
            nchk++;
            if (got_q[i] !== exp_d) begin
               nerr++;
               $display("FAIL stall_order idx=%0d got=%h required=%h", i, got_q[i], exp_d);
            end
         end
      end
   endtask

   task automatic test_overlength();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         tick(1, i == 8, 64'hC0 + i, 0, '0, 1);
         nchk++;
         if (obs_r_yumi !== 1'b1 || obs_err !== (i >= 7)) begin
            nerr++;
            $display("FAIL overlength beat=%0d r_yumi=%b err=%b required 1/%b", i + 1, obs_r_yumi, obs_err, i >= 7);
         end
      end
      tick(0, 0, '0, 1, 64'hD0, 1);
      nchk++;
      if (obs_b_yumi !== 1'b1 || obs_err !== 1'b1) begin
         nerr++;
         $display("FAIL overlength_idle b_yumi=%b err=%b required 1/1", obs_b_yumi, obs_err);
      end
      drain();
      nchk++;
      if (obs_err !== 1'b1) begin
         nerr++;
         $display("FAIL err_sticky got=%b required=1", obs_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      tick(1, 0, 64'hE0, 0, '0, 1);
      tick(1, 0, 64'hE1, 0, '0, 1);
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      #1;
      nchk++;
      if (bus.resp_v_o !== 1'b0 || bus.resp_data_o !== '0) begin
         nerr++;
         $display("FAIL async_reset v=%b data=%h required 0/0", bus.resp_v_o, bus.resp_data_o);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1;
      tick(0, 0, '0, 1, 64'hF0, 1);
      nchk++;
      if (obs_b_yumi !== 1'b1 || obs_data !== {1'b0, 1'b1, 64'hF0}) begin
         nerr++;
         $display("FAIL reset_unlock b_yumi=%b got=%h required 1/%h", obs_b_yumi, obs_data, {1'b0, 1'b1, 64'hF0});
      end
      drain();
   endtask

   task automatic test_random();
      logic         rv, rl, bv;
      logic [W-1:0] rd, bd;
      int           left;
      do_reset();
      left = 0;
      rv = 0; rl = 0; rd = '0; bv = 0; bd = '0;
      for (int c = 0; c < 600; c++) begin
         if (!rv && ($urandom_range(0, 3) != 0)) begin
            if (left == 0) left = $urandom_range(1, 11);
            rv = 1;
            rl = (left == 1);
            rd = {$urandom, $urandom};
         end
         if (!bv && ($urandom_range(0, 2) == 0)) begin
            bv = 1;
            bd = {$urandom, $urandom};
         end
         tick(rv, rl, rd, bv, bd, $urandom_range(0, 3) != 0);
         nchk++;
         if (obs_r_yumi !== exp_r_yumi || obs_b_yumi !== exp_b_yumi) begin
            nerr++;
            $display("FAIL rand_yumi cyc=%0d r=%b b=%b required %b/%b", c, obs_r_yumi, obs_b_yumi, exp_r_yumi, exp_b_yumi);
         end
         nchk++;
         if (obs_v !== m_v || (m_v && obs_data !== m_data) || obs_err !== m_err) begin
            nerr++;
            $display("FAIL rand_out cyc=%0d v=%b data=%h err=%b required %b/%h/%b", c, obs_v, obs_data, obs_err, m_v, m_data, m_err);
         end
         if (exp_r_yumi) begin
            rv = 0;
            left = left - 1;
         end
         if (exp_b_yumi) bv = 0;
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      test_reset();
      test_r_burst_blocks_b();
      test_alternation();
      test_stall();
      test_overlength();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
